master_to_slave_mux: RTL

MASTER_TO_SLAVE_MUX -- requirements
Module: master_to_slave_mux

---
 rtl/master_to_slave_mux.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/master_to_slave_mux.sv
// AHB master-to-slave multiplexer: address-phase select, data-phase write-data steering and burst-length tracking.
// Optional protocol checker on Hprot_err is built only when AHB_M2S_PROTCHK_EN is defined.
module master_to_slave_mux #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                              Hclk,
  input  logic                              Hresetn,
  input  logic [MW-1:0]                     Hmaster,
  input  logic                              Hready,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] Haddr_M,
  input  logic [NUM_MASTERS*2-1:0]          Htrans_M,
  input  logic [NUM_MASTERS-1:0]            Hwrite_M,
  input  logic [NUM_MASTERS*3-1:0]          Hsize_M,
  input  logic [NUM_MASTERS*3-1:0]          Hburst_M,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] Hwdata_M,
  output logic [ADDR_WIDTH-1:0]             Haddr,
  output logic [1:0]                        Htrans,
  output logic                              Hwrite,
  output logic [2:0]                        Hsize,
  output logic [2:0]                        Hburst,
  output logic [DATA_WIDTH-1:0]             Hwdata,
  output logic [MW-1:0]                     Hmaster_dp,
  output logic [3:0]                        Hbeats_left,
  output logic                              Hprot_err
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  if (NUM_MASTERS < 1 || NUM_SLAVES < 1) begin : g_bad_cfg
    $error("master_to_slave_mux: NUM_MASTERS and NUM_SLAVES must be at least 1");
  end

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_beats;
  logic [3:0]      w_beats_nxt;
  logic [MW-1:0]   r_dp_master;
  logic            r_dp_write;
  logic [3:0]      w_len_m1;

  // Zero for SINGLE/INCR: only fixed-length bursts are tracked.
  function automatic logic [3:0] burst_len_m1(input logic [2:0] burst);
    case (burst)
      3'b010, 3'b011: burst_len_m1 = 4'd3;
      3'b100, 3'b101: burst_len_m1 = 4'd7;
      3'b110, 3'b111: burst_len_m1 = 4'd15;
      default:        burst_len_m1 = 4'd0;
    endcase
  endfunction

  // Address phase: zero-latency select; an out-of-range owner yields an IDLE bus.
  always_comb begin
    Haddr  = '0;
    Htrans = TR_IDLE;
    Hwrite = 1'b0;
    Hsize  = '0;
    Hburst = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (Hmaster == MW'(i)) begin
        Haddr  = Haddr_M[i*ADDR_WIDTH +: ADDR_WIDTH];
        Htrans = Htrans_M[i*2 +: 2];
        Hwrite = Hwrite_M[i];
        Hsize  = Hsize_M[i*3 +: 3];
        Hburst = Hburst_M[i*3 +: 3];
      end
    end
  end

  // Data phase: write data follows the owner of the last accepted write transfer.
  always_comb begin
    Hwdata = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (r_dp_write && r_dp_master == MW'(i)) begin
        Hwdata = Hwdata_M[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_len_m1 = burst_len_m1(Hburst);

  always_comb begin
    w_state_nxt = r_state;
    w_beats_nxt = r_beats;
    if (Hready) begin
      case (r_state)
        ST_IDLE: begin
          if (Htrans == TR_NONSEQ && w_len_m1 != 4'd0) begin
            w_state_nxt = ST_BURST;
            w_beats_nxt = w_len_m1;
          end
        end
        ST_BURST: begin
          case (Htrans)
            TR_NONSEQ: begin
              w_state_nxt = (w_len_m1 != 4'd0) ? ST_BURST : ST_IDLE;
              w_beats_nxt = w_len_m1;
            end
            TR_SEQ: begin
              w_beats_nxt = r_beats - 4'd1;
              if (r_beats == 4'd1) w_state_nxt = ST_IDLE;
            end
            TR_IDLE: begin
              w_state_nxt = ST_IDLE;
              w_beats_nxt = 4'd0;
            end
            default: ;
          endcase
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_beats_nxt = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_state     <= ST_IDLE;
      r_beats     <= 4'd0;
      r_dp_master <= '0;
      r_dp_write  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_beats <= w_beats_nxt;
      if (Hready) begin
        r_dp_master <= Hmaster;
        r_dp_write  <= Hwrite & Htrans[1];
      end
    end
  end

  assign Hmaster_dp  = r_dp_master;
  assign Hbeats_left = r_beats;

`ifdef AHB_M2S_PROTCHK_EN
  logic r_prot_err;

  // Flags SEQ with no burst in progress, or an owner change in the middle of a burst.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_prot_err <= 1'b0;
    end else begin
      r_prot_err <= Hready &&
                    ((r_state == ST_IDLE  && Htrans == TR_SEQ) ||
                     (r_state == ST_BURST && Hmaster != r_dp_master));
    end
  end

  assign Hprot_err = r_prot_err;
`else
  assign Hprot_err = 1'b0;
`endif

endmodule
